// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Multicycle load/store sequencer sitting between the CPU control FSM and the
// data memory. One request is accepted at a time from IDLE. Alignment and range
// are checked on acceptance. A good request spends WAIT_CYCLES+1 cycles in
// ACCESS driving the DM strobes, then one cycle in DONE. A rejected request goes
// straight to DONE with fault raised and never touches the DM.
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   req              access request, sampled only in IDLE
//   we               1 = store, 0 = load
//   size             00 word, 01 half, 10 byte, 11 illegal
//   sign_ext         sign-extend half/byte loads
//   addr, wdata      byte address, low-aligned store data
//   busy             high in ACCESS and DONE
//   done, fault      one-cycle completion pulse, rejection flag with done
//   fault_addr       address of the last rejected request
//   rdata            memory data register, written by successful loads only
//   dm_MemR/MemWr    DM read / write strobes
//   dm_MemWrBits     DM store size (00 sw, 01 sh, 10 sb)
//   dm_MemRBits      DM load type (000 lw, 001 lhu, 010 lh, 011 lbu, 100 lb)
//   dm_addr, dm_data latched request address and store data
//   dm_ReadData      combinational DM read result
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_LIMIT  = 2048
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] rdata,
  output logic        dm_MemR,
  output logic        dm_MemWr,
  output logic [1:0]  dm_MemWrBits,
  output logic [2:0]  dm_MemRBits,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_data,
  input  logic [31:0] dm_ReadData
);

  localparam logic [1:0]  ST_IDLE   = 2'b00;
  localparam logic [1:0]  ST_ACCESS = 2'b01;
  localparam logic [1:0]  ST_DONE   = 2'b10;
  localparam logic [2:0]  WAIT_INIT = 3'(WAIT_CYCLES);
  localparam logic [31:0] LIMIT     = 32'(ADDR_LIMIT);

  // Reject illegal size, misaligned half/word, and out-of-range addresses.
  function automatic logic req_faults(input logic [1:0] sz, input logic [31:0] a);
    logic f;
    case (sz)
      2'b00:   f = (a[1:0] != 2'b00);
      2'b01:   f = a[0];
      2'b10:   f = 1'b0;
      default: f = 1'b1;
    endcase
    return f | (a >= LIMIT);
  endfunction

  // Load-type encoding expected by the DM read port.
  function automatic logic [2:0] rbits_of(input logic [1:0] sz, input logic sx);
    logic [2:0] b;
    case (sz)
      2'b00:   b = 3'b000;
      2'b01:   b = sx ? 3'b010 : 3'b001;
      2'b10:   b = sx ? 3'b100 : 3'b011;
      default: b = 3'b000;
    endcase
    return b;
  endfunction

  // Store-size encoding expected by the DM write port.
  function automatic logic [1:0] wbits_of(input logic [1:0] sz);
    logic [1:0] b;
    case (sz)
      2'b00:   b = 2'b00;
      2'b01:   b = 2'b01;
      2'b10:   b = 2'b10;
      default: b = 2'b00;
    endcase
    return b;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [2:0]  cnt_r;
  logic        we_r;
  logic [1:0]  size_r;
  logic        sext_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        fault_r;
  logic [31:0] fault_addr_r;
  logic [31:0] rdata_r;
  logic        accept_s;
  logic        req_fault_s;
  logic        in_access_s;
  logic        final_s;

  assign accept_s    = (state_r == ST_IDLE) && req;
  assign req_fault_s = req_faults(size, addr);
  assign in_access_s = (state_r == ST_ACCESS);
  // The counter reading zero marks the last ACCESS cycle.
  assign final_s     = in_access_s && (cnt_r == 3'd0);

  // Next-state selection for the IDLE/ACCESS/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_nxt_s = req_fault_s ? ST_DONE : ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, request registers, wait counter, fault record and MDR.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 3'd0;
      we_r         <= 1'b0;
      size_r       <= 2'b00;
      sext_r       <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      fault_r      <= 1'b0;
      fault_addr_r <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        we_r    <= we;
        size_r  <= size;
        sext_r  <= sign_ext;
        addr_r  <= addr;
        wdata_r <= wdata;
        fault_r <= req_fault_s;
        cnt_r   <= WAIT_INIT;
        if (req_fault_s) begin
          fault_addr_r <= addr;
        end
      end else if (in_access_s && (cnt_r != 3'd0)) begin
        cnt_r <= cnt_r - 3'd1;
      end
      // DM has already formatted the data for the requested load type.
      if (final_s && !we_r) begin
        rdata_r <= dm_ReadData;
      end
    end
  end

  // Outputs are decodes of registered state only; nothing depends on req.
  always_comb begin
    busy         = (state_r != ST_IDLE);
    done         = (state_r == ST_DONE);
    fault        = (state_r == ST_DONE) && fault_r;
    fault_addr   = fault_addr_r;
    rdata        = rdata_r;
    dm_addr      = addr_r;
    dm_data      = wdata_r;
    dm_MemR      = in_access_s && !we_r;
    // Store strobe only on the last ACCESS cycle so DM writes exactly once.
    dm_MemWr     = final_s && we_r;
    dm_MemWrBits = 2'b00;
    dm_MemRBits  = 3'b000;
    if (in_access_s && we_r) begin
      dm_MemWrBits = wbits_of(size_r);
    end else if (in_access_s) begin
      dm_MemRBits = rbits_of(size_r, sext_r);
    end else begin
      dm_MemWrBits = 2'b00;
      dm_MemRBits  = 3'b000;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Four instances with WAIT_CYCLES 0, 1, 2, 7
// share data inputs but have separate req lines. Instances 1 and 2 have a small
// little-endian DM model behind them.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rstn;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_a      [4];
  logic        busy_a     [4];
  logic        done_a     [4];
  logic        fault_a    [4];
  logic [31:0] faddr_a    [4];
  logic [31:0] rdata_a    [4];
  logic        memr_a     [4];
  logic        memwr_a    [4];
  logic [1:0]  wbits_a    [4];
  logic [2:0]  rbits_a    [4];
  logic [31:0] dmaddr_a   [4];
  logic [31:0] dmdata_a   [4];
  logic [31:0] rd_a       [4];
  logic [31:0] mem1 [0:511];
  logic [31:0] mem2 [0:511];

  int checks;
  int errors;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WC = (g == 3) ? 7 : g;
    mem_access_ctrl #(.WAIT_CYCLES(WC), .ADDR_LIMIT(2048)) dut (
      .clk(clk), .rstn(rstn), .req(req_a[g]), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
      .busy(busy_a[g]), .done(done_a[g]), .fault(fault_a[g]),
      .fault_addr(faddr_a[g]), .rdata(rdata_a[g]),
      .dm_MemR(memr_a[g]), .dm_MemWr(memwr_a[g]),
      .dm_MemWrBits(wbits_a[g]), .dm_MemRBits(rbits_a[g]),
      .dm_addr(dmaddr_a[g]), .dm_data(dmdata_a[g]), .dm_ReadData(rd_a[g])
    );
  end

  function automatic logic [31:0] dm_rd(input logic [31:0] w, input logic [1:0] a,
                                        input logic [2:0] b);
    logic [15:0] h;
    logic [7:0]  y;
    h = a[1] ? w[31:16] : w[15:0];
    y = w[{a, 3'b000} +: 8];
    case (b)
      3'b000:  return w;
      3'b001:  return {16'h0000, h};
      3'b010:  return {{16{h[15]}}, h};
      3'b011:  return {24'h000000, y};
      3'b100:  return {{24{y[7]}}, y};
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] dm_wr(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] a, input logic [1:0] b);
    logic [31:0] r;
    r = old;
    case (b)
      2'b00: r = d;
      2'b01: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      2'b10: r[{a, 3'b000} +: 8] = d[7:0];
      default: r = old;
    endcase
    return r;
  endfunction

  assign rd_a[0] = 32'h0000_0000;
  assign rd_a[1] = dm_rd(mem1[dmaddr_a[1][10:2]], dmaddr_a[1][1:0], rbits_a[1]);
  assign rd_a[2] = dm_rd(mem2[dmaddr_a[2][10:2]], dmaddr_a[2][1:0], rbits_a[2]);
  assign rd_a[3] = 32'h0000_0000;

  // DM has no reset: it writes whenever the strobe is high at the edge.
  always @(posedge clk) begin
    if (memwr_a[1])
      mem1[dmaddr_a[1][10:2]] <= dm_wr(mem1[dmaddr_a[1][10:2]], dmdata_a[1],
                                       dmaddr_a[1][1:0], wbits_a[1]);
    if (memwr_a[2])
      mem2[dmaddr_a[2][10:2]] <= dm_wr(mem2[dmaddr_a[2][10:2]], dmdata_a[2],
                                       dmaddr_a[2][1:0], wbits_a[2]);
  end

  // Issue one request on instance inst and watch it until done (bounded).
  task automatic run_req(input int inst, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d,
                         output int done_cyc, output logic flt, output int r_cnt,
                         output int w_cnt, output int w_cyc, output logic [2:0] rb);
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    req_a[inst] = 1'b1;
    @(posedge clk);
    #1 req_a[inst] = 1'b0;
    done_cyc = -1; flt = 1'b0; r_cnt = 0; w_cnt = 0; w_cyc = -1; rb = 3'b000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (memr_a[inst]) begin r_cnt++; rb = rbits_a[inst]; end
      if (memwr_a[inst]) begin w_cnt++; w_cyc = c; end
      if (done_a[inst]) begin done_cyc = c; flt = fault_a[inst]; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a[1], done_a[1], fault_a[1], memr_a[1], memwr_a[1], wbits_a[1], rbits_a[1]} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0", {busy_a[1], done_a[1], fault_a[1], memr_a[1], memwr_a[1], wbits_a[1], rbits_a[1]});
    end
    checks++;
    if ({rdata_a[1], faddr_a[1], dmaddr_a[1], dmdata_a[1]} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h required 0", {rdata_a[1], faddr_a[1], dmaddr_a[1], dmdata_a[1]});
    end
    rstn = 1'b1;
  endtask

  task automatic test_word_store_load();
    int dc, rc, wc, wy; logic f; logic [2:0] rb;
    run_req(1, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, dc, f, rc, wc, wy, rb);
    checks++;
    if (dc !== 3) begin errors++; $display("FAIL sw_done_cycle: got %0d required 3", dc); end
    checks++;
    if (wc !== 1 || wy !== 2 || rc !== 0) begin
      errors++; $display("FAIL sw_strobes: got wr_cnt %0d wr_cyc %0d rd_cnt %0d required 1 2 0", wc, wy, rc);
    end
    checks++;
    if (dmaddr_a[1] !== 32'h10 || dmdata_a[1] !== 32'hDEAD_BEEF || f !== 1'b0) begin
      errors++; $display("FAIL sw_latch: got %h %h fault %b required 00000010 deadbeef 0", dmaddr_a[1], dmdata_a[1], f);
    end
    run_req(1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, dc, f, rc, wc, wy, rb);
    checks++;
    if (rdata_a[1] !== 32'hDEAD_BEEF || dc !== 3 || rc !== 2 || wc !== 0) begin
      errors++; $display("FAIL lw: got rdata %h done %0d rd %0d wr %0d required deadbeef 3 2 0", rdata_a[1], dc, rc, wc);
    end
  endtask

  task automatic test_subword_loads();
    int dc, rc, wc, wy; logic f; logic [2:0] rb;
    run_req(1, 1'b0, 2'b10, 1'b1, 32'h13, 32'h0, dc, f, rc, wc, wy, rb);
    checks++;
    if (rdata_a[1] !== 32'hFFFF_FFDE || rb !== 3'b100) begin
      errors++; $display("FAIL lb: got %h bits %b required ffffffde 100", rdata_a[1], rb);
    end
    run_req(1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, dc, f, rc, wc, wy, rb);
    checks++;
    if (rdata_a[1] !== 32'h0000_00DE || rb !== 3'b011) begin
      errors++; $display("FAIL lbu: got %h bits %b required 000000de 011", rdata_a[1], rb);
    end
    run_req(1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, dc, f, rc, wc, wy, rb);
    checks++;
    if (rdata_a[1] !== 32'hFFFF_BEEF || rb !== 3'b010) begin
      errors++; $display("FAIL lh: got %h bits %b required ffffbeef 010", rdata_a[1], rb);
    end
  endtask

  task automatic test_faults();
    int dc, rc, wc, wy; logic f; logic [2:0] rb;
    logic [1:0]  fsz [4];
    logic [31:0] fad [4];
    logic        fwe [4];
    fsz[0] = 2'b01; fad[0] = 32'h11;  fwe[0] = 1'b0;
    fsz[1] = 2'b00; fad[1] = 32'h12;  fwe[1] = 1'b1;
    fsz[2] = 2'b11; fad[2] = 32'h20;  fwe[2] = 1'b1;
    fsz[3] = 2'b00; fad[3] = 32'h800; fwe[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_req(1, fwe[i], fsz[i], 1'b0, fad[i], 32'h1234_5678, dc, f, rc, wc, wy, rb);
      checks++;
      if (dc !== 1 || f !== 1'b1 || rc !== 0 || wc !== 0) begin
        errors++; $display("FAIL fault_%0d: got done %0d fault %b rd %0d wr %0d required 1 1 0 0", i, dc, f, rc, wc);
      end
      checks++;
      if (faddr_a[1] !== fad[i] || rdata_a[1] !== 32'hFFFF_BEEF) begin
        errors++; $display("FAIL fault_regs_%0d: got faddr %h rdata %h required %h ffffbeef", i, faddr_a[1], rdata_a[1], fad[i]);
      end
    end
  endtask

  task automatic test_wait_extremes();
    int dc, rc, wc, wy; logic f; logic [2:0] rb;
    run_req(0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h1, dc, f, rc, wc, wy, rb);
    checks++;
    if (dc !== 2 || wc !== 1) begin errors++; $display("FAIL w0_store: got done %0d wr %0d required 2 1", dc, wc); end
    run_req(0, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, dc, f, rc, wc, wy, rb);
    checks++;
    if (dc !== 2 || rc !== 1) begin errors++; $display("FAIL w0_load: got done %0d rd %0d required 2 1", dc, rc); end
    run_req(3, 1'b1, 2'b00, 1'b0, 32'h40, 32'h1, dc, f, rc, wc, wy, rb);
    checks++;
    if (dc !== 9 || wc !== 1 || wy !== 8) begin errors++; $display("FAIL w7_store: got done %0d wr %0d at %0d required 9 1 8", dc, wc, wy); end
    run_req(3, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, dc, f, rc, wc, wy, rb);
    checks++;
    if (dc !== 9 || rc !== 8) begin errors++; $display("FAIL w7_load: got done %0d rd %0d required 9 8", dc, rc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] busy_seq;
    logic [7:0] done_seq;
    @(negedge clk);
    we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h0;
    req_a[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      busy_seq[c-1] = busy_a[1];
      done_seq[c-1] = done_a[1];
    end
    checks++;
    if (busy_seq !== 8'b0111_0111) begin errors++; $display("FAIL b2b_busy: got %b required 01110111", busy_seq); end
    checks++;
    if (done_seq !== 8'b0100_0100) begin errors++; $display("FAIL b2b_done: got %b required 01000100", done_seq); end
    @(negedge clk);
    checks++;
    if (busy_a[1] !== 1'b1) begin errors++; $display("FAIL b2b_third: got busy %b required 1", busy_a[1]); end
    req_a[1] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    int dc, rc, wc, wy; logic f; logic [2:0] rb;
    run_req(2, 1'b1, 2'b00, 1'b0, 32'h20, 32'h1122_3344, dc, f, rc, wc, wy, rb);
    checks++;
    if (dc !== 4 || mem2[8] !== 32'h1122_3344) begin
      errors++; $display("FAIL w2_store: got done %0d mem %h required 4 11223344", dc, mem2[8]);
    end
    // Reset at the edge ending the first ACCESS cycle.
    @(negedge clk);
    we = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'hAAAA_AAAA; req_a[2] = 1'b1;
    @(posedge clk);
    #1 req_a[2] = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (mem2[8] !== 32'h1122_3344) begin errors++; $display("FAIL rst_early_mem: got %h required 11223344", mem2[8]); end
    checks++;
    if ({busy_a[2], done_a[2], fault_a[2], memr_a[2], memwr_a[2], wbits_a[2], rbits_a[2]} !== 9'b0 ||
        {rdata_a[2], faddr_a[2], dmaddr_a[2], dmdata_a[2]} !== 128'h0) begin
      errors++; $display("FAIL rst_early_outs: got %b %h required 0", {busy_a[2], done_a[2], memr_a[2], memwr_a[2]}, dmaddr_a[2]);
    end
    checks++;
    if (rdata_a[1] !== 32'h0) begin errors++; $display("FAIL rst_mdr_clear: got %h required 0", rdata_a[1]); end
    rstn = 1'b1;
    // Reset at the edge ending the final ACCESS cycle: the write lands.
    @(negedge clk);
    wdata = 32'hBBBB_BBBB; req_a[2] = 1'b1;
    @(posedge clk);
    #1 req_a[2] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (memwr_a[2] !== 1'b1) begin errors++; $display("FAIL rst_late_strobe: got %b required 1", memwr_a[2]); end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (mem2[8] !== 32'hBBBB_BBBB || busy_a[2] !== 1'b0 || done_a[2] !== 1'b0) begin
      errors++; $display("FAIL rst_late_mem: got %h busy %b done %b required bbbbbbbb 0 0", mem2[8], busy_a[2], done_a[2]);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    clk = 1'b0; rstn = 1'b0;
    we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 4; i++) req_a[i] = 1'b0;
    test_reset();
    test_word_store_load();
    test_subword_loads();
    test_faults();
    test_wait_extremes();
    test_back_to_back();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
